fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction queue between the fetch unit and decode_unit. Buffers fetched
//  {pc, instr} pairs and presents the oldest one to decode with a valid/ready
//  handshake. Decouples I-cache latency from decode stalls. Supports a
//  single-cycle flush on branch mispredict or redirect.
// PARAMETERS
//  DEPTH  8  number of entries; power of two, >= 2
//  CNT_W  $clog2(DEPTH)+1  width of occupancy count (derived, do not override)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  flush      in   1      drop all entries (mispredict/redirect)
//  enq_valid  in   1      fetch presents an entry
//  enq_ready  out  1      buffer can accept an entry this cycle
//  enq_pc     in   32     PC of entering instruction
//  enq_instr  in   32     raw rv32i_word of entering instruction
//  deq_valid  out  1      head entry valid for decode
//  deq_ready  in   1      decode consumes head this cycle
//  deq_pc     out  32     PC of head entry
//  deq_instr  out  32     instr of head entry (drives CTRLWord.instr)
//  count      out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular array of DEPTH entries; head/tail pointers carry one
//    extra wrap bit. empty = (head == tail); full = index equal, wrap bits differ.
//  - Reset (rst_n low, async): head = tail = 0, count = 0, deq_valid = 0,
//    enq_ready = 1. Entry contents are not reset; deq_pc/deq_instr are
//    don't-care while deq_valid = 0.
//  - enq_ready = !full. Depends only on registered state, never on deq_ready.
//  - deq_valid = !empty. deq_pc/deq_instr = array[head]. Registered-state only.
//  - Enqueue fires when enq_valid && enq_ready && !flush: write array[tail],
//    tail += 1 (mod 2*DEPTH).
//  - Dequeue fires when deq_valid && deq_ready && !flush: head += 1.
//  - Latency: no bypass. An entry enqueued in cycle N appears on deq_* in
//    cycle N+1 at the earliest, even when empty.
//  - Simultaneous enq and deq when neither empty nor full: both fire,
//    count unchanged.
//  - Full: enq_ready = 0 even if deq_ready = 1 in the same cycle (no
//    pass-through when full). Space reopens the cycle after a dequeue.
//  - Empty: deq_ready is ignored and head does not move.
//  - count: +1 on enqueue only, -1 on dequeue only, unchanged on both/neither.
//    count is never negative and never above DEPTH.
//  - Flush has priority over everything. In the flush cycle, enq and deq do
//    not fire. Next cycle: head = tail = 0, count = 0, deq_valid = 0.
//    Decode treats the flush-cycle deq_* as killed.
//  - Pointer wrap: indices wrap mod DEPTH; wrap bit toggles on each wrap.
//    Ordering is strictly FIFO across the wrap.
//  - Reset asserted mid-operation: state clears immediately (async). Outputs
//    reach reset values without waiting for a clock edge.
// TESTING
//  1 Reset, then enqueue pc=0x100 instr=0x00500093 in cycle 0 ->
//    deq_valid=0 in cycle 0; cycle 1: deq_valid=1, deq_pc=0x100,
//    deq_instr=0x00500093, count=1.
//  2 Enqueue 8 entries (pc 0x0..0x1C) with deq_ready=0 ->
//    count=8, enq_ready=0; a 9th enq_valid is not accepted. Then
//    deq_ready=1 for 8 cycles -> pcs 0x0..0x1C in order, then deq_valid=0.
//  3 Full buffer with enq_valid=1 and deq_ready=1 in the same cycle ->
//    only the dequeue fires, count=7, and enq_ready=1 the next cycle.
//  4 Steady stream: enq and deq every cycle for 20 cycles with DEPTH=8 ->
//    pointers wrap twice, output pcs are strictly sequential, count stays 1.
//  5 Five entries held, flush=1 with enq_valid=1 and deq_ready=1 ->
//    next cycle count=0, deq_valid=0, enq_ready=1; the flushed enqueue
//    never appears on deq_*.
//  6 Buffer at count=3, rst_n driven low between clock edges ->
//    deq_valid=0 and count=0 before the next edge; the first post-reset
//    enqueue dequeues first.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between fetch and decode.
// Holds {pc, instr} pairs in a circular array and presents the oldest entry
// to decode with a valid/ready handshake. A flush drops every entry in one cycle.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module fetch_buffer #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_instr,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_instr,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] r_head;
    logic [CNT_W-1:0] r_tail;
    logic [63:0]      r_mem [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];

    // Same slot with the same wrap bit means empty; same slot with the wrap
    // bits differing means the tail has lapped the head, i.e. full.
    assign w_empty = (r_head == r_tail);
    assign w_full  = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

    // Flush kills both sides of the handshake in the cycle it is asserted.
    assign w_enq_fire = enq_valid && !w_full && !flush;
    assign w_deq_fire = deq_ready && !w_empty && !flush;

    // Handshake outputs come from registered state only. There is no bypass,
    // so an entry written this cycle cannot show up on deq_* until the next one.
    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;
    assign deq_pc    = r_mem[w_head_idx][63:32];
    assign deq_instr = r_mem[w_head_idx][31:0];

    // Occupancy is the pointer distance. Modulo 2*DEPTH it always lies in 0..DEPTH.
    assign count = r_tail - r_head;

    // Pointer update: async clear on reset, sync clear on flush, else advance on fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + CNT_W'(1);
            if (w_deq_fire) r_head <= r_head + CNT_W'(1);
        end
    end

    // Entry storage: written at the tail slot on an accepted enqueue, never reset.
    always_ff @(posedge clk) begin
        if (w_enq_fire) r_mem[w_tail_idx] <= {enq_pc, enq_instr};
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenarios followed by a randomized phase.
// The reference model is a plain queue of {pc, instr} entries with the
// push/pop/flush rules applied directly; outputs are compared after every clock.
module tb_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_instr;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_pc;
    logic [31:0]      deq_instr;
    logic [CNT_W-1:0] count;

    logic [63:0] modelQ[$];
    int          checkCount;
    int          passCount;
    int          failCount;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compares every DUT output against the model queue.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".deq_valid"}, {31'd0, deq_valid}, {31'd0, modelQ.size() != 0});
        checkOutput({tag, ".enq_ready"}, {31'd0, enq_ready}, {31'd0, modelQ.size() != DEPTH});
        checkOutput({tag, ".count"}, 32'(count), 32'(modelQ.size()));
        if (modelQ.size() != 0) begin
            checkOutput({tag, ".deq_pc"}, deq_pc, modelQ[0][63:32]);
            checkOutput({tag, ".deq_instr"}, deq_instr, modelQ[0][31:0]);
        end
    endtask

    // Drives one cycle of inputs, steps the model across the clock edge,
    // then checks the outputs shortly after that edge.
    task automatic applyStimulus(input string tag, input logic fl, input logic ev,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic dr);
        bit wasFull;
        bit wasEmpty;
        flush     = fl;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = instr;
        deq_ready = dr;
        @(posedge clk);
        wasFull  = (modelQ.size() == DEPTH);
        wasEmpty = (modelQ.size() == 0);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (dr && !wasEmpty) void'(modelQ.pop_front());
            if (ev && !wasFull) modelQ.push_back({pc, instr});
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        enq_valid  = 1'b0;
        enq_pc     = '0;
        enq_instr  = '0;
        deq_ready  = 1'b0;

        // Reset state while reset is held across a clock edge.
        #12;
        checkAll("reset");
        rst_n = 1'b1;

        // Single enqueue, visible one cycle later.
        $display("[TB] single enqueue latency");
        checkOutput("t1.cycle0_deq_valid", {31'd0, deq_valid}, 32'd0);
        applyStimulus("t1.enq", 1'b0, 1'b1, 32'h100, 32'h0050_0093, 1'b0);
        checkOutput("t1.cycle1_pc", deq_pc, 32'h100);
        applyStimulus("t1.drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Fill to full, refuse a ninth, drain in order.
        $display("[TB] fill and drain");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t2.fill", 1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
        checkOutput("t2.full_count", 32'(count), 32'd8);
        applyStimulus("t2.ninth", 1'b0, 1'b1, 32'h999, 32'h999, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t2.drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("t2.empty_valid", {31'd0, deq_valid}, 32'd0);

        // Full buffer with both handshakes asserted: only the dequeue fires.
        $display("[TB] full with enq and deq together");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t3.fill", 1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'(i), 1'b0);
        applyStimulus("t3.both", 1'b0, 1'b1, 32'h300, 32'h300, 1'b1);
        checkOutput("t3.count7", 32'(count), 32'd7);
        checkOutput("t3.reopen", {31'd0, enq_ready}, 32'd1);
        applyStimulus("t3.flush", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Steady stream across two pointer wraps.
        $display("[TB] steady stream");
        applyStimulus("t4.prime", 1'b0, 1'b1, 32'h1000, 32'h1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus("t4.stream", 1'b0, 1'b1, 32'h1000 + 32'(i * 4), 32'(i + 1), 1'b1);
            checkOutput("t4.count1", 32'(count), 32'd1);
        end
        applyStimulus("t4.drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Flush with five entries held and both handshakes asserted.
        $display("[TB] flush");
        for (int i = 0; i < 5; i++)
            applyStimulus("t5.fill", 1'b0, 1'b1, 32'h2000 + 32'(i * 4), 32'(i), 1'b0);
        applyStimulus("t5.flush", 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
        checkOutput("t5.count0", 32'(count), 32'd0);
        applyStimulus("t5.after", 1'b0, 1'b1, 32'h3000, 32'h3, 1'b0);
        checkOutput("t5.new_head", deq_pc, 32'h3000);
        applyStimulus("t5.drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset between edges with three entries held.
        $display("[TB] async reset");
        for (int i = 0; i < 3; i++)
            applyStimulus("t6.fill", 1'b0, 1'b1, 32'h4000 + 32'(i * 4), 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        checkOutput("t6.async_valid", {31'd0, deq_valid}, 32'd0);
        checkOutput("t6.async_count", 32'(count), 32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus("t6.first", 1'b0, 1'b1, 32'h5000, 32'h55, 1'b0);
        applyStimulus("t6.second", 1'b0, 1'b1, 32'h5004, 32'h56, 1'b1);
        checkOutput("t6.order", deq_pc, 32'h5004);
        applyStimulus("t6.drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic against the queue model.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 3) != 0), $urandom, $urandom,
                          ($urandom_range(0, 2) == 0) || (i >= 200 && $urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
